// File: rtl/risc_pkg.sv
// risc_pkg: shared defaults and next-PC source encoding for the RISC fetch path
package risc_pkg;
  localparam int ADDR_W_DEF = 32;
  localparam logic [31:0] RESET_VEC_DEF = 32'h0000_0000;
  localparam logic [31:0] TRAP_VEC_DEF = 32'h0000_0100;
  typedef enum logic [2:0] {SEL_SEQ, SEL_TGT, SEL_REG, SEL_RAS, SEL_TRAP} next_pc_sel_t;
endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: decoder strobes and ALU flags in, fetch address and stack status out
interface pc_sequencer_if #(
  parameter int ADDR_W = 32,
  parameter int RAS_DEPTH = 8
);
  localparam int DW = $clog2(RAS_DEPTH) + 1;
  logic advance;
  logic [31:0] instruction;
  logic b, br, bz, bnz, bcy, bncy, bs, bns, bv, bnv, Call, Ret;
  logic zf, cf, sf, vf;
  logic [ADDR_W-1:0] rs_value;
  logic [ADDR_W-1:0] pc;
  logic redirect;
  logic [DW-1:0] ras_depth;
  logic ras_overflow, ras_underflow;
  modport master (
    output advance, instruction, b, br, bz, bnz, bcy, bncy, bs, bns, bv, bnv, Call, Ret,
    output zf, cf, sf, vf, rs_value,
    input pc, redirect, ras_depth, ras_overflow, ras_underflow
  );
  modport slave (
    input advance, instruction, b, br, bz, bnz, bcy, bncy, bs, bns, bv, bnv, Call, Ret,
    input zf, cf, sf, vf, rs_value,
    output pc, redirect, ras_depth, ras_overflow, ras_underflow
  );
endinterface

// File: rtl/return_stack.sv
// return_stack: LIFO of return addresses; push ignored when full, pop ignored when empty
module return_stack #(
  parameter int W = 32,
  parameter int DEPTH = 8,
  localparam int DW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  din_i,
  output logic [W-1:0]  dout_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [DW-1:0] depth_o
);
  logic [W-1:0] mem_q [DEPTH];
  logic [DW-1:0] depth_q, depth_d;
  logic [DW-2:0] top;
  assign full_o = depth_q == DW'(DEPTH);
  assign empty_o = depth_q == '0;
  assign depth_o = depth_q;
  assign top = (DW-1)'(depth_q - DW'(1));
  assign dout_o = mem_q[top];
  always_comb begin
    depth_d = (push_i && !full_o) ? depth_q + DW'(1) : (pop_i && !empty_o) ? depth_q - DW'(1) : depth_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) depth_q <= '0;
    else depth_q <= depth_d;
  // Contents need no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk)
    if (push_i && !full_o) mem_q[depth_q[DW-2:0]] <= din_i;
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: next-PC selection, PC register and return-address stack control
module pc_sequencer
  import risc_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int RAS_DEPTH = 8,
  parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(RESET_VEC_DEF),
  parameter logic [ADDR_W-1:0] TRAP_VEC = ADDR_W'(TRAP_VEC_DEF)
) (
  input logic clk,
  input logic rst_n,
  pc_sequencer_if.slave bus
);
  localparam int DW = $clog2(RAS_DEPTH) + 1;
  next_pc_sel_t sel;
  logic [ADDR_W-1:0] pc_q, pc_d, seq, tgt, ras_top;
  logic redirect_q, redirect_d, ovf_q, ovf_d, unf_q, unf_d;
  logic cond, push, pop, full, empty;
  logic [DW-1:0] depth;
  logic unused_hi;
  assign unused_hi = ^bus.instruction[31:16];
  assign seq = pc_q + ADDR_W'(4);
  assign tgt = seq + ADDR_W'($signed({bus.instruction[15:0], 2'b00}));
  assign cond = (bus.bz && bus.zf) || (bus.bnz && !bus.zf) || (bus.bcy && bus.cf) || (bus.bncy && !bus.cf)
             || (bus.bs && bus.sf) || (bus.bns && !bus.sf) || (bus.bv && bus.vf) || (bus.bnv && !bus.vf);
  always_comb begin
    sel = bus.Ret ? (empty ? SEL_TRAP : SEL_RAS) : bus.Call ? SEL_TGT : bus.br ? SEL_REG
        : (bus.b || cond) ? SEL_TGT : SEL_SEQ;
  end
  // Ret outranks Call, so a push and a pop can never coincide.
  assign push = bus.advance && bus.Call && !bus.Ret;
  assign pop = bus.advance && bus.Ret;
  always_comb begin
    pc_d = !bus.advance ? pc_q : sel == SEL_RAS ? ras_top : sel == SEL_TRAP ? TRAP_VEC
         : sel == SEL_REG ? {bus.rs_value[ADDR_W-1:2], 2'b00} : sel == SEL_TGT ? tgt : seq;
    redirect_d = bus.advance && sel != SEL_SEQ;
    ovf_d = ovf_q || (push && full);
    unf_d = unf_q || (pop && empty);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pc_q <= RESET_VEC;
      redirect_q <= 1'b0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q <= pc_d;
      redirect_q <= redirect_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  return_stack #(.W(ADDR_W), .DEPTH(RAS_DEPTH)) u_ras (
    .clk(clk), .rst_n(rst_n), .push_i(push), .pop_i(pop), .din_i(seq),
    .dout_o(ras_top), .full_o(full), .empty_o(empty), .depth_o(depth)
  );
  assign bus.pc = pc_q;
  assign bus.redirect = redirect_q;
  assign bus.ras_depth = depth;
  assign bus.ras_overflow = ovf_q;
  assign bus.ras_underflow = unf_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed and random control-flow checks against a queue-based model
module tb_pc_sequencer;
  localparam int DEPTH = 8;
  localparam logic [31:0] TRAP = 32'h100;
  localparam logic [11:0] S_B = 12'h800, S_BR = 12'h400, S_BZ = 12'h200, S_CALL = 12'h002, S_RET = 12'h001;
  logic clk = 1'b0, rst_n = 1'b1;
  int tests = 0, fails = 0;
  logic [31:0] m_pc;
  logic m_redir, m_ovf, m_unf;
  logic [31:0] m_stk[$];
  pc_sequencer_if #(.ADDR_W(32), .RAS_DEPTH(DEPTH)) bus();
  pc_sequencer #(.ADDR_W(32), .RAS_DEPTH(DEPTH), .RESET_VEC(32'h0), .TRAP_VEC(TRAP))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".pc"}, bus.pc, m_pc);
    chk({tag, ".redirect"}, 32'(bus.redirect), 32'(m_redir));
    chk({tag, ".depth"}, 32'(bus.ras_depth), 32'(m_stk.size()));
    chk({tag, ".ovf"}, 32'(bus.ras_overflow), 32'(m_ovf));
    chk({tag, ".unf"}, 32'(bus.ras_underflow), 32'(m_unf));
  endtask

  task automatic model_reset();
    m_pc = 32'h0;
    m_redir = 1'b0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
    m_stk.delete();
  endtask

  // s = {b, br, bz, bnz, bcy, bncy, bs, bns, bv, bnv, Call, Ret}, f = {zf, cf, sf, vf}
  task automatic step(input string tag, input bit adv, input logic [11:0] s, input logic [15:0] off,
                      input logic [3:0] f, input logic [31:0] rs);
    logic [31:0] seq, tgt, nx;
    bit cond;
    bus.advance = adv;
    {bus.b, bus.br, bus.bz, bus.bnz, bus.bcy, bus.bncy, bus.bs, bus.bns, bus.bv, bus.bnv, bus.Call, bus.Ret} = s;
    bus.instruction = {16'($urandom), off};
    {bus.zf, bus.cf, bus.sf, bus.vf} = f;
    bus.rs_value = rs;
    seq = m_pc + 32'd4;
    tgt = seq + 32'(int'($signed(off)) * 4);
    cond = (s[9] && f[3]) || (s[8] && !f[3]) || (s[7] && f[2]) || (s[6] && !f[2])
        || (s[5] && f[1]) || (s[4] && !f[1]) || (s[3] && f[0]) || (s[2] && !f[0]);
    if (!adv) m_redir = 1'b0;
    else begin
      m_redir = s[0] || s[1] || s[10] || s[11] || cond;
      if (s[0]) begin
        if (m_stk.size() == 0) begin nx = TRAP; m_unf = 1'b1; end
        else nx = m_stk.pop_back();
      end else if (s[1]) begin
        if (m_stk.size() < DEPTH) m_stk.push_back(seq);
        else m_ovf = 1'b1;
        nx = tgt;
      end else if (s[10]) nx = rs & 32'hFFFF_FFFC;
      else if (s[11] || cond) nx = tgt;
      else nx = seq;
      m_pc = nx;
    end
    @(posedge clk);
    #1;
    chk_all(tag);
  endtask

  task automatic rand_steps(input int n);
    for (int i = 0; i < n; i++) begin
      int r;
      logic [11:0] s;
      r = $urandom_range(0, 15);
      s = r < 12 ? 12'(1 << r) : r == 13 ? 12'($urandom) : 12'h0;
      step("rand", $urandom_range(0, 9) != 0, s, 16'($urandom), 4'($urandom), $urandom);
    end
  endtask

  initial begin
    bus.advance = 1'b0;
    bus.instruction = '0;
    {bus.b, bus.br, bus.bz, bus.bnz, bus.bcy, bus.bncy, bus.bs, bus.bns, bus.bv, bus.bnv, bus.Call, bus.Ret} = '0;
    {bus.zf, bus.cf, bus.sf, bus.vf} = '0;
    bus.rs_value = '0;
    model_reset();
    #7 rst_n = 1'b0;
    #1 chk_all("reset");
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step("seq", 1, 12'h0, 16'h0, 4'h0, 32'h0);
    chk("seq_lit", bus.pc, 32'hC);

    step("br100", 1, S_BR, 16'h0, 4'h0, 32'h100);
    step("b_back", 1, S_B, 16'hFFFE, 4'h0, 32'h0);
    chk("b_lit", bus.pc, 32'hFC);
    chk("b_redir_lit", 32'(bus.redirect), 32'd1);
    step("br100", 1, S_BR, 16'h0, 4'h0, 32'h100);
    step("bz_nt", 1, S_BZ, 16'h0010, 4'b0000, 32'h0);
    chk("bz_nt_lit", bus.pc, 32'h104);
    step("br100", 1, S_BR, 16'h0, 4'h0, 32'h100);
    step("bz_t", 1, S_BZ, 16'h0010, 4'b1000, 32'h0);
    chk("bz_t_lit", bus.pc, 32'h144);
    step("br_align", 1, S_BR, 16'h0, 4'h0, 32'h2003);
    chk("br_lit", bus.pc, 32'h2000);

    for (int i = 0; i < 8; i++)
      for (int v = 0; v < 2; v++) begin
        logic [3:0] f;
        f = 4'($urandom);
        f[3 - i / 2] = (v == 1);
        step("cond", 1, 12'(S_BZ >> i), 16'($urandom_range(0, 64)), f, 32'h0);
      end

    step("br40", 1, S_BR, 16'h0, 4'h0, 32'h40);
    step("call1", 1, S_CALL, 16'h0008, 4'h0, 32'h0);
    chk("call1_lit", bus.pc, 32'h64);
    step("call2", 1, S_CALL, 16'h0004, 4'h0, 32'h0);
    step("ret2", 1, S_RET, 16'h0, 4'h0, 32'h0);
    chk("ret2_lit", bus.pc, 32'h68);
    step("ret1", 1, S_RET, 16'h0, 4'h0, 32'h0);
    chk("ret1_lit", bus.pc, 32'h44);

    for (int i = 0; i < 9; i++) step("call_fill", 1, S_CALL, 16'h0, 4'h0, 32'h0);
    chk("ovf_lit", 32'(bus.ras_overflow), 32'd1);
    chk("depth8_lit", 32'(bus.ras_depth), 32'd8);
    for (int i = 0; i < 8; i++) step("ret_drain", 1, S_RET, 16'h0, 4'h0, 32'h0);
    step("ret_empty", 1, S_RET, 16'h0, 4'h0, 32'h0);
    chk("trap_lit", bus.pc, TRAP);
    chk("unf_lit", 32'(bus.ras_underflow), 32'd1);

    step("stall", 0, S_B, 16'h0040, 4'h0, 32'h0);
    step("call_pre", 1, S_CALL, 16'h0010, 4'h0, 32'h0);
    step("ret_vs_b", 1, S_RET | S_B, 16'h0040, 4'h0, 32'h0);
    rand_steps(200);
    chk("ovf_sticky", 32'(bus.ras_overflow), 32'd1);

    #3 rst_n = 1'b0;
    model_reset();
    #1 chk_all("midreset");
    @(negedge clk) rst_n = 1'b1;
    rand_steps(300);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Next-PC generator and return-address stack for the single-cycle RISC core. It consumes the branch/call/return strobes produced by the `ControlUnit` decoder and the ALU status flags, and produces the instruction-fetch address that feeds the next instruction word back to that decoder. It closes the control-flow loop on the fetch side of the decoder interface.

## Interface
Parameters:
- `ADDR_W`, 32: byte-address width of PC.
- `RAS_DEPTH`, 8: return-address stack entries (power of 2, ≥2).
- `RESET_VEC`, 32'h0000_0000: PC after reset.
- `TRAP_VEC`, 32'h0000_0100: PC taken on stack underflow.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `advance`  in  1  1 = commit current instruction and update PC; 0 = hold everything (memory stall).
- `instruction`  in  32  current instruction word; offset in [15:0].
- `b, br, bz, bnz, bcy, bncy, bs, bns, bv, bnv, Call, Ret`  in  1 each  decoder strobes.
- `zf, cf, sf, vf`  in  1 each  ALU status flags for current instruction.
- `rs_value`  in  ADDR_W  register operand used as `br` target.
- `pc`  out  ADDR_W  current fetch address (registered).
- `redirect`  out  1  registered; 1 for one cycle after a taken control transfer.
- `ras_depth`  out  $clog2(RAS_DEPTH)+1  current stack occupancy.
- `ras_overflow`  out  1  sticky; push attempted while full.
- `ras_underflow`  out  1  sticky; pop attempted while empty.

## Operation
- `seq = pc + 4`; `tgt = seq + (sext(instruction[15:0]) << 2)`, mod 2^ADDR_W (wrap-around, no error).
- Next-PC priority when `advance=1` (multiple strobes is illegal but defined): `Ret` > `Call` > `br` > `b` > conditional > `seq`.
- `Ret`: pop; next = popped value. If empty: next = `TRAP_VEC`, set `ras_underflow`, depth stays 0.
- `Call`: push `seq`; next = `tgt`. If full: no write, depth stays `RAS_DEPTH`, set `ras_overflow`, jump still taken.
- `br`: next = `rs_value` with bits [1:0] forced to 0.
- `b`: next = `tgt`.
- Conditional: `bz`/`bnz` on zf=1/0, `bcy`/`bncy` on cf, `bs`/`bns` on sf, `bv`/`bnv` on vf; taken → `tgt`, else `seq`.
- Taken = any of Ret, Call, br, b, or a satisfied conditional.
- `advance=0`: pc, stack, depth, sticky flags hold; `redirect` clears to 0.
- Sticky flags clear only on reset.

## Timing
- Reset (async assert, sync-safe deassert on rising edge): pc=`RESET_VEC`, redirect=0, ras_depth=0, ras_overflow=0, ras_underflow=0; stack contents don't-care.
- One instruction per cycle: next-PC combinational from current-cycle inputs, registered at rising edge when `advance=1`; latency 1 cycle.
- `redirect` asserted the cycle after the edge that committed a taken transfer.
- Push and pop never occur in the same cycle (priority guarantees it).
- Stack is LIFO; pop returns the most recent unpopped push; after overflow the top entry is the last successful push.
- Reset mid-operation: stack empties immediately, no pending pop/push survives.

## Structure
- Shared package `risc_pkg`: `ADDR_W` default, `RESET_VEC`/`TRAP_VEC` defaults, enum `next_pc_sel_t` {SEL_SEQ, SEL_TGT, SEL_REG, SEL_RAS, SEL_TRAP}.
- Sub-module `return_stack`: RAS_DEPTH×ADDR_W LIFO with push/pop/full/empty/depth, same clock and reset; pc_sequencer holds select logic and PC register.

## Test plan
- Reset: hold rst_n=0 mid-cycle → pc=0x0, all flags 0; release, advance=1, no strobes, 3 cycles → pc=0x4, 0x8, 0xC, redirect=0.
- Branches at pc=0x100: `b` with offset 0xFFFE → pc=0xFC, redirect=1; `bz` zf=0 offset 0x0010 → pc=0x104, redirect=0; `bz` zf=1 → pc=0x144.
- `br` with rs_value=0x0000_2003 → pc=0x2000; all eight conditionals exercised with flag true/false.
- Call/Ret: at pc=0x40 `Call` offset 0x0008 → pc=0x64, depth=1; nested call; two `Ret` → pc returns to inner then 0x44, depth=0.
- RAS limits: 9 Calls with RAS_DEPTH=8 → ras_overflow=1, depth=8; `Ret` on empty stack → pc=0x100, ras_underflow=1, both stay set until reset.
- Stall/priority: `advance=0` with `b` asserted → pc holds; `Ret` and `b` together → Ret wins.
